// File: rtl/capture_reader_pkg.sv
// -----------------------------------------------------------------------------
// capture_reader_pkg
//   Shared definitions for the ADC capture double-buffer reader.
//   - Default bank geometry shared with the capture driver.
//   - Reader FSM state encoding.
// -----------------------------------------------------------------------------
package capture_reader_pkg;

    // Default bank geometry, kept in step with the capture driver.
    localparam int DEPTH_DEF  = 11;
    localparam int DATA_W_DEF = 8;

    // Reader FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        LOAD  = 3'd2,
        READ  = 3'd3,
        FLUSH = 3'd4
    } state_t;

endpackage

// File: rtl/capture_reader_sync_fifo2.sv
// -----------------------------------------------------------------------------
// sync_fifo2
//   Two-entry synchronous FIFO. It absorbs the one-cycle RAM read latency so
//   the reader can stream one sample per cycle under downstream backpressure.
//   The caller guarantees that it never pushes when full and never pops when
//   empty.
//
// Ports
//   i_clk    in   clock
//   i_rst_n  in   synchronous active-low reset (empties the FIFO)
//   i_push   in   write i_data
//   i_data   in   W   entry to write
//   i_pop    in   discard the head entry
//   o_data   out  W   head entry (valid when o_count != 0)
//   o_count  out  2   number of stored entries (0..2)
// -----------------------------------------------------------------------------
module sync_fifo2 #(
    parameter int W = 9
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic [1:0]   o_count
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/capture_reader.sv
// -----------------------------------------------------------------------------
// capture_reader
//   Consumer end of the ADC capture double-buffer. On a host start request it
//   arms the bank-swap handshake with the capture driver, latches the frozen
//   bank and the trigger address, then reads the whole 2^DEPTH-sample bank in
//   circular order starting PRETRIG samples before the trigger and streams it
//   downstream over valid/ready at one sample per cycle.
//
// Ports
//   clk         in   system clock
//   rst_n       in   synchronous active-low reset
//   start       in   one-cycle frame request, ignored unless idle
//   busy        out  high from accepted start until the frame completes
//   frame_done  out  one-cycle pulse after the last sample is accepted
//   ready       out  to capture driver: bank swap will be accepted
//   valid       in   from capture driver: a filled bank is available
//   bank_sel    in   capture driver's current write bank
//   trig_addr   in   DEPTH   trigger address published by the capture driver
//   rd_bank     out  RAM bank select for the reads
//   rd_addr     out  DEPTH   RAM read address
//   rd_en       out  RAM read strobe (data returns the following cycle)
//   rd_data     in   DATA_W  RAM read data
//   out_data    out  DATA_W  sample to downstream
//   out_valid   out  out_data valid
//   out_ready   in   downstream accepts
//   out_last    out  final sample of the frame, qualified by out_valid
// -----------------------------------------------------------------------------
module capture_reader
    import capture_reader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRETRIG = 2 ** (DEPTH - 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              ready,
    input  logic              valid,
    input  logic              bank_sel,
    input  logic [DEPTH-1:0]  trig_addr,
    output logic              rd_bank,
    output logic [DEPTH-1:0]  rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [DEPTH-1:0] PRE_OFS  = DEPTH'(PRETRIG);
    localparam logic [DEPTH:0]   LAST_CNT = {1'b0, {DEPTH{1'b1}}};
    localparam logic [DEPTH:0]   CNT_ONE  = {{DEPTH{1'b0}}, 1'b1};

    // First address of the frame; the DEPTH-bit subtraction gives the
    // modulo-2^DEPTH wrap for free.
    function automatic logic [DEPTH-1:0] f_start_addr(input logic [DEPTH-1:0] trig);
        return trig - PRE_OFS;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rd_bank;
    logic [DEPTH-1:0]  r_start_addr;
    logic [DEPTH:0]    r_cnt;          // reads issued this frame, 0..2^DEPTH
    logic              r_rd_q;         // read issued last cycle: rd_data is live
    logic              r_rd_last_q;    // that read was the final one of the frame
    logic              r_frame_done;

    logic              w_pop;
    logic              w_rd_en;
    logic              w_last_rd;
    logic              w_last_pop;
    logic [1:0]        w_fifo_cnt;
    logic [DATA_W:0]   w_fifo_dout;
    logic [2:0]        w_occupancy;

    // Occupancy after this edge if nothing new is issued: stored entries plus
    // the read in flight minus the one leaving. Issue only while that leaves
    // room for one more, so FIFO plus in-flight never exceeds two.
    assign w_pop       = out_valid & out_ready;
    assign w_occupancy = {1'b0, w_fifo_cnt} + {2'b00, r_rd_q} - {2'b00, w_pop};
    assign w_rd_en     = (r_state == READ) && !r_cnt[DEPTH] && (w_occupancy <= 3'd1);
    assign w_last_rd   = w_rd_en && (r_cnt == LAST_CNT);
    assign w_last_pop  = w_pop && w_fifo_dout[DATA_W];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)      w_state_nxt = ARM;
            ARM:     if (valid)      w_state_nxt = LOAD;
            LOAD:                    w_state_nxt = READ;
            READ:    if (w_last_rd)  w_state_nxt = FLUSH;
            FLUSH:   if (w_last_pop) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rd_bank    <= 1'b0;
            r_start_addr <= '0;
            r_cnt        <= '0;
            r_rd_q       <= 1'b0;
            r_rd_last_q  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_q       <= w_rd_en;
            r_rd_last_q  <= w_last_rd;
            r_frame_done <= (r_state == FLUSH) && w_last_pop;
            // The driver toggles bank_sel on this same edge, so the value
            // seen here is the bank it has just finished filling.
            if ((r_state == ARM) && valid) begin
                r_rd_bank <= bank_sel;
            end
            // trig_addr is published on the handshake edge, hence sampled
            // one cycle later in LOAD.
            if (r_state == LOAD) begin
                r_start_addr <= f_start_addr(trig_addr);
                r_cnt        <= '0;
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    sync_fifo2 #(
        .W(DATA_W + 1)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (r_rd_q),
        .i_data  ({r_rd_last_q, rd_data}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_dout),
        .o_count (w_fifo_cnt)
    );

    assign ready      = (r_state == ARM);
    assign busy       = (r_state != IDLE);
    assign frame_done = r_frame_done;
    assign rd_bank    = r_rd_bank;
    assign rd_addr    = r_start_addr + r_cnt[DEPTH-1:0];
    assign rd_en      = w_rd_en;
    assign out_valid  = (w_fifo_cnt != 2'd0);
    assign out_data   = w_fifo_dout[DATA_W-1:0];
    assign out_last   = out_valid & w_fifo_dout[DATA_W];

endmodule

// File: doc/capture_reader.md
Name: capture_reader

Overview:
- Consumer end of the ADC capture double-buffer.
- On a host `start` request it asserts `ready` to the ADC capture driver and waits for the `ready & valid` bank-swap handshake. It then latches the frozen bank and trigger address.
- It reads the full 2^DEPTH-sample bank out of the sample RAM in circular order, beginning PRETRIG samples before the trigger point.
- Samples stream downstream (SPI/host link) over a valid/ready interface with one-sample-per-cycle throughput under backpressure.

Parameters:
- DEPTH, 11, address width of one bank; frame length = 2^DEPTH samples.
- DATA_W, 8, sample width.
- PRETRIG, 2^(DEPTH-1), number of samples output before the trigger sample; legal range 0..2^DEPTH-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  single-cycle request for one frame; ignored unless idle.
- busy  out  1  high from the accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last sample is accepted.
- ready  out  1  to capture driver: reader will accept a bank swap.
- valid  in  1  from capture driver: a filled bank is available.
- bank_sel  in  1  capture driver's current write bank.
- trig_addr  in  DEPTH  trigger address published by the capture driver.
- rd_bank  out  1  bank being read (RAM bank select).
- rd_addr  out  DEPTH  RAM read address.
- rd_en  out  1  RAM read strobe; RAM returns rd_data in the following cycle.
- rd_data  in  DATA_W  RAM read data.
- out_data  out  DATA_W  sample to downstream.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_last  out  1  marks the final sample of the frame; qualified by out_valid.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - ready, busy, frame_done, rd_en, out_valid, out_last = 0.
  - rd_addr=0, rd_bank=0.
  - FIFO emptied, read counter = 0.
  - Reset mid-frame abandons the frame with no frame_done. The driver keeps valid high, so the next start handshakes immediately.
- ready is a pure state decode: ready = (state==ARM).
- busy = (state != IDLE).
- Handshake occurs in any cycle with ready & valid.
- States:
  - IDLE: start=1 -> ARM.
  - ARM: ready=1. On ready & valid: latch rd_bank <= bank_sel (pre-toggle value; the driver toggles its bank on this same edge), then -> LOAD. If valid is already high on ARM entry, the handshake happens in the first ARM cycle.
  - LOAD: exactly one cycle. The driver updates trig_addr on the handshake edge, so trig_addr is sampled here. Set start_addr = (trig_addr - PRETRIG) mod 2^DEPTH, read counter = 0, -> READ.
  - READ: issue reads until 2^DEPTH have been issued, then -> FLUSH.
    - rd_addr = (start_addr + count) mod 2^DEPTH; wraps 2^DEPTH-1 -> 0.
    - Counter is DEPTH+1 bits.
  - FLUSH: wait for the final sample's out handshake, then -> IDLE with frame_done=1 for that one cycle. busy is already low in that cycle.
- Read flow control (2-entry output FIFO, RAM latency 1):
  - rd_q = registered rd_en, i.e. data is present on rd_data this cycle.
  - pop = out_valid & out_ready.
  - rd_en = (state==READ) & count<2^DEPTH & (fifo_cnt + rd_q - pop <= 1).
  - FIFO write = rd_q.
  - Sustained out_ready=1 gives 1 sample/cycle after a 2-cycle initial latency (first rd_en to first out_valid).
  - The FIFO never overflows and never drops a sample.
- out_last is stored per FIFO entry; set on the entry from the read with count = 2^DEPTH-1.
- start while busy: ignored.
- out_ready held low: rd_en stalls once FIFO+inflight=2. rd_addr and out_data are held stable.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=0, ARM=1, LOAD=2, READ=3, FLUSH=4 (3 bits);
  - DEPTH/DATA_W defaults shared with the capture driver.
- One sub-module, sync_fifo2: 2-entry, DATA_W+1 wide (data plus last flag), with push/pop, count[1:0], and synchronous active-low reset.

Test Plan:
- DEPTH=4, PRETRIG=8, trig_addr=3 (presented the cycle after the handshake), bank_sel=1 at handshake -> rd_bank=1; rd_addr 11,12,13,14,15,0,...,10 (16 reads); out_last on the 16th sample; frame_done 1 cycle after the last accept.
- out_ready tied 1, valid already high at start -> handshake in the first ARM cycle; 16 consecutive out_valid cycles with no bubbles.
- out_ready toggling 1,0,0,1 pattern -> no sample lost or duplicated; out_data stable while out_valid & !out_ready; at most 2 samples outstanding.
- valid held low for 50 cycles in ARM -> ready stays 1, no rd_en; raise valid -> frame proceeds normally.
- start pulsed during READ -> ignored; exactly one frame, one frame_done.
- rst_n=0 for 1 cycle after 5 samples are delivered -> next cycle all outputs 0; new start plus handshake gives a full 16-sample frame.
